// File: rtl/main_mul_pipe_hs.sv
// Pipelined multiplier with a per-stage valid/ready handshake and backpressure.
// Define MAIN_MUL_PIPE_SAT_EN to clamp out-of-range results instead of wrapping them.
module main_mul_pipe_hs #(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 2,
    parameter int din0_WIDTH  = 42,
    parameter int din1_WIDTH  = 33,
    parameter int dout_WIDTH  = 75,
    parameter int din0_SIGNED = 0,
    parameter int din1_SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  sat,
    output logic                  busy
);
    localparam int P    = din0_WIDTH + din1_WIDTH;
    localparam int LAST = NUM_STAGE - 1;
    localparam int unusedId = ID;

    logic [P-1:0]          extA;
    logic [P-1:0]          extB;
    logic [P-1:0]          prod;
    logic [P-1:0]          lastIn;
    logic [LAST:0]         v_q;
    logic [LAST:0]         v_d;
    logic [LAST:0]         acc;
    logic [LAST:0]         vIn;
    logic [LAST:0]         load;
    logic                  chain;
    logic [dout_WIDTH-1:0] dout_d;
    logic [dout_WIDTH-1:0] dout_q;

    // Extending both operands to the full product width keeps the low P bits exact for any signedness.
    assign extA = {{din1_WIDTH{(din0_SIGNED != 0) & din0[din0_WIDTH-1]}}, din0};
    assign extB = {{din0_WIDTH{(din1_SIGNED != 0) & din1[din1_WIDTH-1]}}, din1};
    assign prod = extA * extB;

    // Acceptance ripples from the consumer back to the input: a stage can take data if it is empty or draining.
    always_comb begin
        acc   = '0;
        chain = ce & out_ready;
        for (int k = LAST; k >= 0; k--) begin
            acc[k] = ce & (~v_q[k] | chain);
            chain  = acc[k];
        end
    end

    always_comb begin
        vIn    = '0;
        vIn[0] = in_valid;
        for (int k = 1; k <= LAST; k++) begin
            vIn[k] = v_q[k-1];
        end
    end

    assign load = acc & vIn;
    assign v_d  = (acc & vIn) | (~acc & v_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    generate
        if (NUM_STAGE > 1) begin : gPipe
            logic [P-1:0] pipe_q [LAST];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < LAST; k++) begin
                        pipe_q[k] <= '0;
                    end
                end else begin
                    if (load[0]) begin
                        pipe_q[0] <= prod;
                    end
                    for (int k = 1; k < LAST; k++) begin
                        if (load[k]) begin
                            pipe_q[k] <= pipe_q[k-1];
                        end
                    end
                end
            end

            assign lastIn = pipe_q[LAST-1];
        end else begin : gNoPipe
            assign lastIn = prod;
        end
    endgenerate

`ifdef MAIN_MUL_PIPE_SAT_EN
    localparam bit RES_SIGNED = (din0_SIGNED != 0) || (din1_SIGNED != 0);

    logic sat_d;
    logic sat_q;

    generate
        if (dout_WIDTH == P) begin : gFull
            assign dout_d = lastIn;
            assign sat_d  = 1'b0;
        end else if (RES_SIGNED) begin : gSigned
            // In range only when every bit from the result sign bit upward agrees.
            logic [P-dout_WIDTH:0] hi;
            logic                  ovf;

            assign hi     = lastIn[P-1:dout_WIDTH-1];
            assign ovf    = ~((&hi) | ~(|hi));
            assign sat_d  = ovf;
            assign dout_d = ovf ? {lastIn[P-1], {(dout_WIDTH-1){~lastIn[P-1]}}}
                                : lastIn[dout_WIDTH-1:0];
        end else begin : gUnsigned
            logic ovf;

            assign ovf    = |lastIn[P-1:dout_WIDTH];
            assign sat_d  = ovf;
            assign dout_d = ovf ? '1 : lastIn[dout_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_q <= 1'b0;
        end else if (load[LAST]) begin
            sat_q <= sat_d;
        end
    end

    assign sat = sat_q;
`else
    generate
        if (dout_WIDTH == P) begin : gFull
            assign dout_d = lastIn;
        end else begin : gTrunc
            logic [P-dout_WIDTH-1:0] unusedHi;

            assign unusedHi = lastIn[P-1:dout_WIDTH];
            assign dout_d   = lastIn[dout_WIDTH-1:0];
        end
    endgenerate

    assign sat = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q <= '0;
        end else if (load[LAST]) begin
            dout_q <= dout_d;
        end
    end

    assign in_ready  = acc[0];
    assign out_valid = v_q[LAST];
    assign busy      = |v_q;
    assign dout      = dout_q;

endmodule

// File: tb/tb_main_mul_pipe_hs.sv
// Bench for main_mul_pipe_hs: four parameterisations, directed vectors, a scoreboard fed by an
// arithmetic model of multiply-and-reduce, and literal expectations for the headline cases.
`timescale 1ns/1ps
module tb_main_mul_pipe_hs;
    logic         clk      = 1'b0;
    logic         reset    = 1'b0;
    logic         ce       = 1'b1;
    logic [127:0] opA      = '0;
    logic [127:0] opB      = '0;
    logic [3:0]   inValid  = '0;
    logic [3:0]   outReady = 4'hF;
    logic [3:0]   inReady;
    logic [3:0]   outValid;
    logic [3:0]   satV;
    logic [3:0]   busyV;
    logic [74:0]  dout0;
    logic [74:0]  dout1;
    logic [15:0]  dout2;
    logic [15:0]  dout3;
    logic [127:0] doutW [4];
    logic [128:0] expQ [4][$];
    int           popCnt [4] = '{default: 0};
    int           checks = 0;
    int           errors = 0;

    logic [127:0] bpA [5] = '{128'd5, 128'hFF9, 128'd2047, 128'h800, 128'd1000};
    logic [127:0] bpB [5] = '{128'd6, 128'd9,   128'd2047, 128'h800, 128'd3};

`ifdef MAIN_MUL_PIPE_SAT_EN
    localparam logic [15:0] T4_DOUT = 16'hFFFF;
    localparam logic        T4_SAT  = 1'b1;
    localparam logic [15:0] T5_DOUT = 16'h8000;
    localparam logic        T5_SAT  = 1'b1;
`else
    localparam logic [15:0] T4_DOUT = 16'd57345;
    localparam logic        T4_SAT  = 1'b0;
    localparam logic [15:0] T5_DOUT = 16'h0800;
    localparam logic        T5_SAT  = 1'b0;
`endif

    always #5 clk = ~clk;

    main_mul_pipe_hs #(.ID(1), .NUM_STAGE(2), .din0_WIDTH(42), .din1_WIDTH(33), .dout_WIDTH(75),
                       .din0_SIGNED(0), .din1_SIGNED(0)) dutA (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .din0(opA[41:0]), .din1(opB[32:0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
        .dout(dout0), .sat(satV[0]), .busy(busyV[0]));

    main_mul_pipe_hs #(.ID(2), .NUM_STAGE(2), .din0_WIDTH(42), .din1_WIDTH(33), .dout_WIDTH(75),
                       .din0_SIGNED(1), .din1_SIGNED(0)) dutS (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .din0(opA[41:0]), .din1(opB[32:0]), .out_valid(outValid[1]), .out_ready(outReady[1]),
        .dout(dout1), .sat(satV[1]), .busy(busyV[1]));

    main_mul_pipe_hs #(.ID(3), .NUM_STAGE(3), .din0_WIDTH(12), .din1_WIDTH(12), .dout_WIDTH(16),
                       .din0_SIGNED(1), .din1_SIGNED(1)) dutB (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .din0(opA[11:0]), .din1(opB[11:0]), .out_valid(outValid[2]), .out_ready(outReady[2]),
        .dout(dout2), .sat(satV[2]), .busy(busyV[2]));

    main_mul_pipe_hs #(.ID(4), .NUM_STAGE(1), .din0_WIDTH(12), .din1_WIDTH(12), .dout_WIDTH(16),
                       .din0_SIGNED(0), .din1_SIGNED(0)) dutC (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(inValid[3]), .in_ready(inReady[3]),
        .din0(opA[11:0]), .din1(opB[11:0]), .out_valid(outValid[3]), .out_ready(outReady[3]),
        .dout(dout3), .sat(satV[3]), .busy(busyV[3]));

    assign doutW[0] = {53'd0, dout0};
    assign doutW[1] = {53'd0, dout1};
    assign doutW[2] = {112'd0, dout2};
    assign doutW[3] = {112'd0, dout3};

    // Exact product as an integer, then wrapped or clamped into wo bits; result is {sat, dout}.
    function automatic logic [128:0] mulModel(input logic [127:0] a, input logic [127:0] b,
                                              input int wa, input int wb, input int wo,
                                              input bit sa, input bit sb);
        logic signed [159:0] one;
        logic signed [159:0] av;
        logic signed [159:0] bv;
        logic signed [159:0] p;
        logic [127:0]        mask;
        logic [127:0]        d;
        logic                s;
        one = 160'sd1;
        av  = '0;
        bv  = '0;
        av[127:0] = a & ((128'd1 << wa) - 128'd1);
        bv[127:0] = b & ((128'd1 << wb) - 128'd1);
        if (sa && (((a >> (wa - 1)) & 128'd1) != 128'd0)) av = av - (one <<< wa);
        if (sb && (((b >> (wb - 1)) & 128'd1) != 128'd0)) bv = bv - (one <<< wb);
        p    = av * bv;
        mask = (128'd1 << wo) - 128'd1;
        d    = p[127:0] & mask;
        s    = 1'b0;
`ifdef MAIN_MUL_PIPE_SAT_EN
        if (sa || sb) begin
            if (p > (one <<< (wo - 1)) - one) begin
                d = mask >> 1;
                s = 1'b1;
            end else if (p < -(one <<< (wo - 1))) begin
                d = (mask >> 1) + 128'd1;
                s = 1'b1;
            end
        end else if (p > (one <<< wo) - one) begin
            d = mask;
            s = 1'b1;
        end
`endif
        return {s, d};
    endfunction

    function automatic logic [128:0] modelFor(input int d, input logic [127:0] a, input logic [127:0] b);
        case (d)
            0:       return mulModel(a, b, 42, 33, 75, 1'b0, 1'b0);
            1:       return mulModel(a, b, 42, 33, 75, 1'b1, 1'b0);
            2:       return mulModel(a, b, 12, 12, 16, 1'b1, 1'b1);
            default: return mulModel(a, b, 12, 12, 16, 1'b0, 1'b0);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [128:0] act, input logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic applyStimulus(input int d, input logic [127:0] a, input logic [127:0] b, output int waits);
        waits = 0;
        opA = a;
        opB = b;
        inValid[d] = 1'b1;
        @(negedge clk);
        while (!inReady[d] && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!inReady[d]) checkOutput($sformatf("push_timeout%0d", d), 129'd0, 129'd1);
        @(posedge clk);
        #1;
        inValid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while ((expQ[d].size() != 0 || outValid[d]) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput($sformatf("drain%0d", d), {128'd0, (expQ[d].size() != 0)}, 129'd0);
    endtask

    // Scoreboard: record accepted operands, compare every valid output against the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) expQ[i].delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (inValid[i] && inReady[i]) expQ[i].push_back(modelFor(i, opA, opB));
                if (outValid[i]) begin
                    if (expQ[i].size() == 0) begin
                        checkOutput($sformatf("dut%0d_spurious", i), 129'd1, 129'd0);
                    end else begin
                        checkOutput($sformatf("dut%0d_result", i), {satV[i], doutW[i]}, expQ[i][0]);
                        if (outReady[i] && ce) begin
                            void'(expQ[i].pop_front());
                            popCnt[i]++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        int accepted;
        int popBefore;
        logic [15:0] heldB;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rst_out_valid%0d", i), {128'd0, outValid[i]}, 129'd0);
            checkOutput($sformatf("rst_busy%0d", i), {128'd0, busyV[i]}, 129'd0);
            checkOutput($sformatf("rst_sat%0d", i), {128'd0, satV[i]}, 129'd0);
            checkOutput($sformatf("rst_in_ready%0d", i), {128'd0, inReady[i]}, 129'd1);
            checkOutput($sformatf("rst_dout%0d", i), {1'b0, doutW[i]}, 129'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        checkOutput("model_t1", modelFor(0, (128'd1 << 42) - 1, (128'd1 << 33) - 1),
                    {1'b0, (128'd1 << 75) - (128'd1 << 42) - (128'd1 << 33) + 128'd1});
        applyStimulus(0, (128'd1 << 42) - 1, (128'd1 << 33) - 1, w);
        @(negedge clk);
        checkOutput("t1_not_yet", {128'd0, outValid[0]}, 129'd0);
        @(negedge clk);
        checkOutput("t1_valid", {128'd0, outValid[0]}, 129'd1);
        checkOutput("t1_dout", {54'd0, dout0}, (128'd1 << 75) - (128'd1 << 42) - (128'd1 << 33) + 128'd1);
        @(posedge clk);
        #1;

        applyStimulus(1, (128'd1 << 42) - 3, 128'd5, w);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t2_valid", {128'd0, outValid[1]}, 129'd1);
        checkOutput("t2_dout", {54'd0, dout1}, (128'd1 << 75) - 128'd15);
        checkOutput("t2_sat", {128'd0, satV[1]}, 129'd0);
        @(posedge clk);
        #1;

        applyStimulus(0, 128'd123456789, 128'd987654, w);
        checkOutput("tp_wait0", w, 0);
        applyStimulus(0, (128'd1 << 41) + 7, (128'd1 << 32) + 3, w);
        checkOutput("tp_wait1", w, 0);
        applyStimulus(0, 128'd0, 128'd12345, w);
        checkOutput("tp_wait2", w, 0);
        applyStimulus(0, 128'd1, 128'd1, w);
        checkOutput("tp_wait3", w, 0);
        drain(0);
        checkOutput("tp_popcount", popCnt[0], 5);

        applyStimulus(3, 128'd4095, 128'd4095, w);
        @(negedge clk);
        checkOutput("t4_valid", {128'd0, outValid[3]}, 129'd1);
        checkOutput("t4_dout", {113'd0, dout3}, {113'd0, T4_DOUT});
        checkOutput("t4_sat", {128'd0, satV[3]}, {128'd0, T4_SAT});
        @(posedge clk);
        #1;
        applyStimulus(3, 128'd100, 128'd200, w);
        @(negedge clk);
        checkOutput("t4b_dout", {113'd0, dout3}, 129'd20000);
        @(posedge clk);
        #1;

        applyStimulus(2, 128'h800, 128'h7FF, w);
        @(negedge clk);
        checkOutput("t5_not_yet", {128'd0, outValid[2]}, 129'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5_valid", {128'd0, outValid[2]}, 129'd1);
        checkOutput("t5_dout", {113'd0, dout2}, {113'd0, T5_DOUT});
        checkOutput("t5_sat", {128'd0, satV[2]}, {128'd0, T5_SAT});
        @(posedge clk);
        #1;
        applyStimulus(2, 128'hFFD, 128'd5, w);
        drain(2);

        popBefore = popCnt[2];
        outReady[2] = 1'b0;
        accepted = 0;
        for (int j = 0; j < 8 && accepted < 5; j++) begin
            opA = bpA[accepted];
            opB = bpB[accepted];
            inValid[2] = 1'b1;
            @(negedge clk);
            if (inReady[2]) accepted++;
            @(posedge clk);
            #1;
        end
        inValid[2] = 1'b0;
        checkOutput("bp_accepted", accepted, 3);
        checkOutput("bp_in_ready_low", {128'd0, inReady[2]}, 129'd0);
        checkOutput("bp_busy", {128'd0, busyV[2]}, 129'd1);
        outReady[2] = 1'b1;
        #1;
        checkOutput("bp_in_ready_pop", {128'd0, inReady[2]}, 129'd1);
        applyStimulus(2, bpA[3], bpB[3], w);
        checkOutput("bp_push_pop_wait", w, 0);
        applyStimulus(2, bpA[4], bpB[4], w);
        drain(2);
        checkOutput("bp_popcount", popCnt[2] - popBefore, 5);

        outReady[2] = 1'b0;
        applyStimulus(2, 128'd11, 128'd13, w);
        applyStimulus(2, 128'hFF0, 128'd100, w);
        applyStimulus(2, 128'd300, 128'd300, w);
        ce = 1'b0;
        outReady[2] = 1'b1;
        heldB = dout2;
        checkOutput("frz_front", {113'd0, heldB}, 129'd143);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checkOutput("frz_in_ready", {125'd0, inReady}, 129'd0);
            checkOutput("frz_out_valid", {128'd0, outValid[2]}, 129'd1);
            checkOutput("frz_dout", {113'd0, dout2}, {113'd0, heldB});
            checkOutput("frz_busy", {128'd0, busyV[2]}, 129'd1);
        end
        @(posedge clk);
        #1;
        outReady[2] = 1'b0;
        ce = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arst_out_valid", {128'd0, outValid[2]}, 129'd0);
        checkOutput("arst_busy", {128'd0, busyV[2]}, 129'd0);
        checkOutput("arst_dout", {113'd0, dout2}, 129'd0);
        checkOutput("arst_sat", {128'd0, satV[2]}, 129'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        outReady[2] = 1'b1;

        applyStimulus(2, 128'd7, 128'hFF7, w);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("post_rst_dout", {113'd0, dout2}, 129'hFFC1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) drain(i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
